// File: rtl/cache_assoc.sv
// Set-associative (1 or 2 way, LRU) write-through, no-write-allocate cache between a word port and a line-wide memory port.
// Define CACHE_STATS_EN to build saturating read hit/miss counters; otherwise hit_count/miss_count are tied to 0.
module cache_assoc #(
  parameter int WORD_SIZE  = 16,
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 4,
  parameter int WAYS       = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            readC,
  input  logic                            writeC,
  input  logic [WORD_SIZE-1:0]            address,
  input  logic [WORD_SIZE-1:0]            wdata_dp,
  output logic [WORD_SIZE-1:0]            rdata_dp,
  output logic                            readyC,
  output logic                            readM,
  output logic                            writeM,
  output logic [WORD_SIZE-1:0]            addressM,
  output logic [WORD_SIZE*LINE_WORDS-1:0] wdataM,
  output logic [LINE_WORDS-1:0]           wmaskM,
  input  logic [WORD_SIZE*LINE_WORDS-1:0] rdataM,
  input  logic                            readyM,
  output logic [15:0]                     hit_count,
  output logic [15:0]                     miss_count
);

  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(SETS);
  localparam int IDX_B  = (IDX_W > 0) ? IDX_W : 1;
  localparam int NSET   = 1 << IDX_B;
  localparam int TAG_W  = WORD_SIZE - OFF_W - IDX_W;
  localparam int LINE_W = WORD_SIZE * LINE_WORDS;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;
  state_t state, state_nxt;

  logic [OFF_W-1:0]     off;
  logic [IDX_B-1:0]     idx;
  logic [TAG_W-1:0]     tag;
  logic [WORD_SIZE-1:0] aligned;

  assign off     = address[OFF_W-1:0];
  assign idx     = (IDX_W > 0) ? IDX_B'(address >> OFF_W) : '0;
  assign tag     = TAG_W'(address >> (OFF_W + IDX_W));
  assign aligned = address & ~WORD_SIZE'(LINE_WORDS - 1);

  // Way storage is always two deep; way 1 is never validated when WAYS=1.
  logic                 valid_q [2][NSET];
  logic                 lru_q   [NSET];
  logic [TAG_W-1:0]     tag_q   [2][NSET];
  logic [WORD_SIZE-1:0] data_q  [2][NSET][LINE_WORDS];

  logic [OFF_W-1:0] req_off_p1;
  logic [IDX_B-1:0] req_idx_p1;
  logic [TAG_W-1:0] req_tag_p1;
  logic             victim_p1;

  logic                 hit0, hit1, hit, hit_way, victim;
  logic [WORD_SIZE-1:0] hit_word, fill_word;

  assign hit0    = valid_q[0][idx] && (tag_q[0][idx] == tag);
  assign hit1    = (WAYS == 2) && valid_q[1][idx] && (tag_q[1][idx] == tag);
  assign hit     = hit0 || hit1;
  assign hit_way = hit1;
  assign hit_word  = data_q[hit_way][idx][off];
  assign fill_word = rdataM[req_off_p1*WORD_SIZE +: WORD_SIZE];

  always_comb begin
    victim = 1'b0;
    if (!valid_q[0][idx])
      victim = 1'b0;
    else if ((WAYS == 2) && !valid_q[1][idx])
      victim = 1'b1;
    else if (WAYS == 2)
      victim = lru_q[idx];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (writeC)
          state_nxt = WRITE;
        else if (readC)
          state_nxt = hit ? DONE : FILL;
      end
      FILL:    if (readyM) state_nxt = DONE;
      WRITE:   if (readyM) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign readyC = (state == DONE);
  assign readM  = (state == FILL);
  assign writeM = (state == WRITE);

  // IDLE decision edge: latch request, update LRU/outputs; FILL completion edge: install line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      valid_q    <= '{default: '0};
      lru_q      <= '{default: '0};
      rdata_dp   <= '0;
      addressM   <= '0;
      wdataM     <= '0;
      wmaskM     <= '0;
      req_off_p1 <= '0;
      req_idx_p1 <= '0;
      req_tag_p1 <= '0;
      victim_p1  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (writeC) begin
            addressM <= aligned;
            wdataM   <= LINE_W'(wdata_dp) << (off * WORD_SIZE);
            wmaskM   <= LINE_WORDS'(1) << off;
            if (hit && (WAYS == 2)) lru_q[idx] <= ~hit_way;
          end else if (readC) begin
            if (hit) begin
              rdata_dp <= hit_word;
              if (WAYS == 2) lru_q[idx] <= ~hit_way;
            end else begin
              addressM   <= aligned;
              wdataM     <= '0;
              wmaskM     <= '0;
              req_off_p1 <= off;
              req_idx_p1 <= idx;
              req_tag_p1 <= tag;
              victim_p1  <= victim;
            end
          end
        end
        FILL: begin
          if (readyM) begin
            valid_q[victim_p1][req_idx_p1] <= 1'b1;
            rdata_dp <= fill_word;
            if (WAYS == 2) lru_q[req_idx_p1] <= ~victim_p1;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag and data arrays carry no reset; validity alone decides whether they are used.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && writeC && hit)
      data_q[hit_way][idx][off] <= wdata_dp;
    if ((state == FILL) && readyM) begin
      tag_q[victim_p1][req_idx_p1] <= req_tag_p1;
      for (int k = 0; k < LINE_WORDS; k++)
        data_q[victim_p1][req_idx_p1][OFF_W'(k)] <= rdataM[k*WORD_SIZE +: WORD_SIZE];
    end
  end

`ifdef CACHE_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if ((state == IDLE) && readC && !writeC) begin
      if (hit)
        hit_count <= sat_inc(hit_count);
      else
        miss_count <= sat_inc(miss_count);
    end
  end
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_assoc.sv
// Directed bench for cache_assoc (default parameters: 16-bit words, 4-word lines, 4 sets, 2 ways).
module tb_cache_assoc;

  logic        clk = 1'b0;
  logic        reset, readC, writeC, readyC, readM, writeM, readyM;
  logic [15:0] address, wdata_dp, rdata_dp, addressM, hit_count, miss_count;
  logic [63:0] wdataM, rdataM;
  logic [3:0]  wmaskM;

  logic [15:0] mem [256];
  int total = 0;
  int bad   = 0;

  logic [15:0] rd, am;
  logic [3:0]  mk;
  logic [63:0] wdl;
  int          lat;
  bit          srm, swm, both;

  cache_assoc dut (
    .clk(clk), .reset(reset), .readC(readC), .writeC(writeC),
    .address(address), .wdata_dp(wdata_dp), .rdata_dp(rdata_dp),
    .readyC(readyC), .readM(readM), .writeM(writeM),
    .addressM(addressM), .wdataM(wdataM), .wmaskM(wmaskM),
    .rdataM(rdataM), .readyM(readyM),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  // Drives one request and acts as memory: readyM rises after wt extra cycles of readM/writeM.
  task automatic access(input bit wr, input logic [15:0] a, input logic [15:0] wd, input int wt,
                        output logic [15:0] o_rd, output int o_lat, output bit o_rm, output bit o_wm,
                        output logic [15:0] o_am, output logic [3:0] o_mk, output logic [63:0] o_wd,
                        output bit o_both);
    int mcnt = 0;
    int b;
    o_rd = '0; o_lat = -1; o_rm = 0; o_wm = 0; o_am = '0; o_mk = '0; o_wd = '0; o_both = 0;
    @(posedge clk); #1;
    address = a; wdata_dp = wd; readC = !wr; writeC = wr;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      readyM = 1'b0;
      if (readM && writeM) o_both = 1;
      if (readyC) begin
        o_rd = rdata_dp; o_lat = c;
        break;
      end
      if (readM || writeM) begin
        if (mcnt == 0) begin o_am = addressM; o_mk = wmaskM; o_wd = wdataM; end
        o_rm = o_rm | readM;
        o_wm = o_wm | writeM;
        mcnt++;
        if (mcnt == wt + 1) begin
          b = int'(addressM[7:0]);
          if (writeM)
            for (int k = 0; k < 4; k++)
              if (wmaskM[k]) mem[(b + k) % 256] = wdataM[k*16 +: 16];
          rdataM = {mem[(b+3)%256], mem[(b+2)%256], mem[(b+1)%256], mem[b]};
          readyM = 1'b1;
        end
      end
    end
    readC = 0; writeC = 0; readyM = 0;
  endtask

  task automatic test_reset;
    reset = 1'b1; readC = 0; writeC = 0; readyM = 0; address = '0; wdata_dp = '0; rdataM = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (readyC !== 1'b0) begin bad++; $display("FAIL reset_readyC: got %b want 0", readyC); end
    total++; if (readM !== 1'b0 || writeM !== 1'b0) begin bad++; $display("FAIL reset_mem_req: got %b%b want 00", readM, writeM); end
    total++; if (addressM !== 16'h0 || wmaskM !== 4'h0) begin bad++; $display("FAIL reset_addr_mask: got %h %h want 0 0", addressM, wmaskM); end
    total++; if (wdataM !== 64'h0 || rdata_dp !== 16'h0) begin bad++; $display("FAIL reset_data: got %h %h want 0 0", wdataM, rdata_dp); end
    total++; if (hit_count !== 16'h0 || miss_count !== 16'h0) begin bad++; $display("FAIL reset_counters: got %h %h want 0 0", hit_count, miss_count); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    total++; if (readyC !== 1'b0 || readM !== 1'b0) begin bad++; $display("FAIL reset_release_idle: got %b%b want 00", readyC, readM); end
  endtask

  task automatic test_cold_read;
    access(0, 16'h0012, 16'h0, 3, rd, lat, srm, swm, am, mk, wdl, both);
    total++; if (srm !== 1'b1) begin bad++; $display("FAIL cold_readM: got %b want 1", srm); end
    total++; if (am !== 16'h0010) begin bad++; $display("FAIL cold_addressM: got %h want 0010", am); end
    total++; if (lat !== 5) begin bad++; $display("FAIL cold_latency: got %0d want 5", lat); end
    total++; if (rd !== 16'hA012) begin bad++; $display("FAIL cold_rdata: got %h want A012", rd); end
    access(0, 16'h0013, 16'h0, 0, rd, lat, srm, swm, am, mk, wdl, both);
    total++; if (srm !== 1'b0 || lat !== 1) begin bad++; $display("FAIL follow_hit: got readM=%b lat=%0d want 0 1", srm, lat); end
    total++; if (rd !== 16'hA013) begin bad++; $display("FAIL follow_rdata: got %h want A013", rd); end
  endtask

  task automatic test_lru;
    logic [15:0] addrs [7] = '{16'h0000, 16'h0010, 16'h0000, 16'h0020, 16'h0000, 16'h0010, 16'h0000};
    bit          miss  [7] = '{1, 0, 0, 1, 0, 1, 0};
    logic [15:0] want;
    for (int i = 0; i < 7; i++) begin
      access(0, addrs[i], 16'h0, 0, rd, lat, srm, swm, am, mk, wdl, both);
      want = 16'hA000 + addrs[i];
      total++; if (srm !== miss[i]) begin bad++; $display("FAIL lru_step%0d_readM: got %b want %b", i, srm, miss[i]); end
      total++; if (rd !== want || lat !== (miss[i] ? 2 : 1)) begin bad++; $display("FAIL lru_step%0d_data: got %h lat %0d want %h lat %0d", i, rd, lat, want, miss[i] ? 2 : 1); end
    end
  endtask

  task automatic test_write_hit;
    access(1, 16'h0012, 16'hBEEF, 1, rd, lat, srm, swm, am, mk, wdl, both);
    total++; if (swm !== 1'b1 || srm !== 1'b0 || both !== 1'b0) begin bad++; $display("FAIL wh_req: got w=%b r=%b both=%b want 1 0 0", swm, srm, both); end
    total++; if (mk !== 4'b0100) begin bad++; $display("FAIL wh_mask: got %b want 0100", mk); end
    total++; if (wdl !== 64'h0000_BEEF_0000_0000) begin bad++; $display("FAIL wh_wdataM: got %h want 0000BEEF00000000", wdl); end
    total++; if (am !== 16'h0010 || lat !== 3) begin bad++; $display("FAIL wh_addr_lat: got %h %0d want 0010 3", am, lat); end
    access(0, 16'h0012, 16'h0, 0, rd, lat, srm, swm, am, mk, wdl, both);
    total++; if (rd !== 16'hBEEF || srm !== 1'b0 || lat !== 1) begin bad++; $display("FAIL wh_readback: got %h readM=%b lat=%0d want BEEF 0 1", rd, srm, lat); end
  endtask

  task automatic test_write_miss;
    access(1, 16'h0040, 16'h1234, 2, rd, lat, srm, swm, am, mk, wdl, both);
    total++; if (swm !== 1'b1 || srm !== 1'b0) begin bad++; $display("FAIL wm_req: got w=%b r=%b want 1 0", swm, srm); end
    total++; if (mk !== 4'b0001 || wdl !== 64'h0000_0000_0000_1234 || am !== 16'h0040) begin bad++; $display("FAIL wm_line: got %b %h %h want 0001 1234 0040", mk, wdl, am); end
    total++; if (lat !== 4) begin bad++; $display("FAIL wm_latency: got %0d want 4", lat); end
    access(0, 16'h0040, 16'h0, 0, rd, lat, srm, swm, am, mk, wdl, both);
    total++; if (srm !== 1'b1 || rd !== 16'h1234) begin bad++; $display("FAIL wm_no_alloc: got readM=%b rd=%h want 1 1234", srm, rd); end
  endtask

  task automatic test_back_to_back;
    logic [5:0] pat;
    @(posedge clk); #1;
    address = 16'h0041; readC = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      pat[i] = readyC;
    end
    readC = 1'b0;
    total++; if (pat !== 6'b010101) begin bad++; $display("FAIL b2b_ready_pattern: got %b want 010101", pat); end
    total++; if (rdata_dp !== 16'hA041) begin bad++; $display("FAIL b2b_rdata: got %h want A041", rdata_dp); end
  endtask

  task automatic test_idle_ready;
    @(posedge clk); #1;
    readyM = 1'b1;
    @(posedge clk); #1;
    readyM = 1'b0;
    total++; if (readyC !== 1'b0 || readM !== 1'b0 || writeM !== 1'b0) begin bad++; $display("FAIL idle_readyM: got %b%b%b want 000", readyC, readM, writeM); end
  endtask

  task automatic test_reset_mid_fill;
    bit seen = 0;
    @(posedge clk); #1;
    address = 16'h0080; readC = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (readM) begin seen = 1; break; end
    end
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL rst_fill_start: got %b want 1", seen); end
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    total++; if (readM !== 1'b0 || readyC !== 1'b0) begin bad++; $display("FAIL rst_fill_drop: got readM=%b readyC=%b want 0 0", readM, readyC); end
    total++; if (rdata_dp !== 16'h0 || addressM !== 16'h0) begin bad++; $display("FAIL rst_fill_clear: got %h %h want 0 0", rdata_dp, addressM); end
    readC = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    access(0, 16'h0080, 16'h0, 1, rd, lat, srm, swm, am, mk, wdl, both);
    total++; if (srm !== 1'b1 || rd !== 16'hA080) begin bad++; $display("FAIL rst_repeat_miss: got readM=%b rd=%h want 1 A080", srm, rd); end
    access(0, 16'h0010, 16'h0, 0, rd, lat, srm, swm, am, mk, wdl, both);
    total++; if (srm !== 1'b1) begin bad++; $display("FAIL rst_invalidated: got readM=%b want 1", srm); end
    access(0, 16'h0020, 16'h0, 0, rd, lat, srm, swm, am, mk, wdl, both);
    access(0, 16'h0021, 16'h0, 0, rd, lat, srm, swm, am, mk, wdl, both);
    total++; if (srm !== 1'b0 || rd !== 16'hA021) begin bad++; $display("FAIL rst_hit1: got readM=%b rd=%h want 0 A021", srm, rd); end
    access(0, 16'h0011, 16'h0, 0, rd, lat, srm, swm, am, mk, wdl, both);
    total++; if (srm !== 1'b0 || rd !== 16'hA011) begin bad++; $display("FAIL rst_hit2: got readM=%b rd=%h want 0 A011", srm, rd); end
`ifdef CACHE_STATS_EN
    total++; if (miss_count !== 16'd3 || hit_count !== 16'd2) begin bad++; $display("FAIL stats: got miss=%0d hit=%0d want 3 2", miss_count, hit_count); end
`else
    total++; if (miss_count !== 16'd0 || hit_count !== 16'd0) begin bad++; $display("FAIL stats_off: got miss=%0d hit=%0d want 0 0", miss_count, hit_count); end
`endif
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'hA000 + 16'(i);
    test_reset();
    test_cold_read();
    test_lru();
    test_write_hit();
    test_write_miss();
    test_back_to_back();
    test_idle_ready();
    test_reset_mid_fill();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
